// File: rtl/uart_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb_pkg
// Description : Shared types and helpers for the UART transmit arbiter:
//               FSM state encoding and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_LAUNCH    = 2'd1,
        ARB_WAIT_DONE = 2'd2
    } arb_state_e;

    // Width of an index able to address n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first set
//               request index at or after ptr_i, wrapping to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   grant_o,
    output logic               any_o
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[cand]) begin
                grant_o = cand;
                any_o   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter sharing one uart_tx between NUM_REQ
//               byte requesters, with launch timeout and per-requester
//               ack / done / error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int LAUNCH_TIMEOUT = 64
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_REQ-1:0]             req_valid_in,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_in,
    output logic [NUM_REQ-1:0]             req_ack_out,
    output logic [NUM_REQ-1:0]             req_done_out,
    output logic [NUM_REQ-1:0]             req_err_out,
    output logic [DATA_BITS-1:0]           tx_data_out,
    output logic                           tx_data_rdy_out,
    input  logic                           tx_busy_in,
    input  logic                           tx_done_in,
    output logic [idx_width(NUM_REQ)-1:0]  grant_id_out,
    output logic                           arb_busy_out
);

    localparam int                IDX_W    = idx_width(NUM_REQ);
    localparam int                CNT_W    = idx_width(LAUNCH_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q,   ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [DATA_BITS-1:0]   data_q,  data_d;
    logic                   rdy_q,   rdy_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [NUM_REQ-1:0]     ack_q,   ack_d;
    logic [NUM_REQ-1:0]     done_q,  done_d;
    logic [NUM_REQ-1:0]     err_q,   err_d;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic [IDX_W-1:0]       ptr_next;
    logic [DATA_BITS-1:0]   req_bytes [NUM_REQ];

    // Unpack the flat request data bus into one byte per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes[gi] = req_data_in[gi*DATA_BITS +: DATA_BITS];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (req_valid_in),
        .ptr_i   (ptr_q),
        .grant_o (pick_idx),
        .any_o   (pick_any)
    );

    // After serving requester g the search resumes at g+1, wrapping.
    assign ptr_next = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;

    // State and registered outputs; reset aborts any transfer silently.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; busy wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) state_d = ARB_LAUNCH;
            end
            ARB_LAUNCH: begin
                if (tx_busy_in)             state_d = ARB_WAIT_DONE;
                else if (cnt_q == CNT_LAST) state_d = ARB_IDLE;
            end
            ARB_WAIT_DONE: begin
                if (tx_done_in) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Next values of the datapath and pulse outputs for each state.
    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        rdy_d   = 1'b0;
        ack_d   = '0;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d         = pick_idx;
                    data_d          = req_bytes[pick_idx];
                    ack_d[pick_idx] = 1'b1;
                    cnt_d           = '0;
                    rdy_d           = 1'b1;
                end
            end
            ARB_LAUNCH: begin
                if (tx_busy_in) begin
                    rdy_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    err_d[grant_q] = 1'b1;
                    ptr_d          = ptr_next;
                end else begin
                    rdy_d = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ARB_WAIT_DONE: begin
                if (tx_done_in) begin
                    done_d[grant_q] = 1'b1;
                    ptr_d           = ptr_next;
                end
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    assign req_ack_out     = ack_q;
    assign req_done_out    = done_q;
    assign req_err_out     = err_q;
    assign tx_data_out     = data_q;
    assign tx_data_rdy_out = rdy_q;
    assign grant_id_out    = grant_q;
    assign arb_busy_out    = (state_q != ARB_IDLE);

endmodule
`default_nettype wire
